// File: rtl/i2c_target_regs.sv
// I2C target with pointer-then-data register protocol and a local register port.
// Define I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         NUM_REGS = 16,
    parameter int         AW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          lcl_we,
    input  logic [AW-1:0] lcl_addr,
    input  logic [7:0]    lcl_wdata,
    output logic [7:0]    lcl_rdata,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_RD_MACK,
        S_RD_NEXT,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic scl_s1_q, scl_s2_q;
    logic sda_s1_q, sda_s2_q;
    logic scl_f, sda_f;
    logic scl_p_q, sda_p_q;

    logic scl_rise, scl_fall;
    logic start, stop;

    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;

    logic [7:0] regs_q [NUM_REGS];

    logic       bus_we;
    logic [7:0] bus_wdata;
    logic [7:0] shift_in;
    logic [7:0] rd_byte;
    logic       byte_done;
    logic       addr_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_h_q, sda_h_q;
    logic       scl_m_q, sda_m_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_h_q <= 2'b11;
            sda_h_q <= 2'b11;
            scl_m_q <= 1'b1;
            sda_m_q <= 1'b1;
        end else begin
            scl_h_q <= {scl_h_q[0], scl_s2_q};
            sda_h_q <= {sda_h_q[0], sda_s2_q};
            scl_m_q <= (scl_s2_q & scl_h_q[0]) |
                       (scl_s2_q & scl_h_q[1]) |
                       (scl_h_q[0] & scl_h_q[1]);
            sda_m_q <= (sda_s2_q & sda_h_q[0]) |
                       (sda_s2_q & sda_h_q[1]) |
                       (sda_h_q[0] & sda_h_q[1]);
        end
    end

    assign scl_f = scl_m_q;
    assign sda_f = sda_m_q;
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_p_q <= scl_f;
            sda_p_q <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_p_q;
    assign scl_fall = ~scl_f & scl_p_q;
    assign start    = scl_f & scl_p_q & sda_p_q & ~sda_f;
    assign stop     = scl_f & scl_p_q & ~sda_p_q & sda_f;

    assign shift_in  = {shift_q[6:0], sda_f};
    assign bus_wdata = shift_in;
    assign rd_byte   = regs_q[ptr_q];
    assign byte_done = (cnt_q == 4'd8);
    assign addr_hit  = (shift_q[7:1] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_ADDR;
        end else if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_fall && byte_done) begin
                        state_d = addr_hit ? S_ADDR_ACK : S_IDLE;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_d = shift_q[0] ? S_RD : S_PTR;
                    end
                end
                S_PTR: begin
                    if (scl_fall && byte_done) begin
                        state_d = S_PTR_ACK;
                    end
                end
                S_PTR_ACK: begin
                    if (scl_fall) begin
                        state_d = S_WR;
                    end
                end
                S_WR: begin
                    if (scl_fall && byte_done) begin
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d = S_WR;
                    end
                end
                S_RD: begin
                    if (scl_fall && byte_done) begin
                        state_d = S_RD_MACK;
                    end
                end
                S_RD_MACK: begin
                    if (scl_rise) begin
                        state_d = sda_f ? S_WAIT : S_RD_NEXT;
                    end
                end
                S_RD_NEXT: begin
                    if (scl_fall) begin
                        state_d = S_RD;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        bus_we    = 1'b0;
        if (start) begin
            cnt_d    = 4'd0;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop) begin
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (scl_fall && byte_done) begin
                        sda_oe_d = addr_hit;
                        busy_d   = addr_hit;
                    end
                end
                S_PTR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (scl_fall && byte_done) begin
                        sda_oe_d = 1'b1;
                        ptr_d    = shift_q[AW-1:0];
                    end
                end
                S_WR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            bus_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            ptr_d     = ptr_q + AW'(1);
                        end
                    end
                    if (scl_fall && byte_done) begin
                        sda_oe_d = 1'b1;
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK, S_RD_NEXT: begin
                    if (scl_fall) begin
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                        // Read bytes are captured at the fall that ends the ACK slot.
                        if (state_q == S_RD_NEXT ||
                            (state_q == S_ADDR_ACK && shift_q[0])) begin
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end
                    end
                end
                S_RD: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (byte_done) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RD_MACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Bus write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (lcl_we) begin
                regs_q[lcl_addr] <= lcl_wdata;
            end
            if (bus_we) begin
                regs_q[ptr_q] <= bus_wdata;
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign lcl_rdata = regs_q[lcl_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, local-port vector table,
// directed corner sequences and random transactions against a register model.
module tb_i2c_target_regs;

    localparam int         Q   = 6;
    localparam logic [6:0] DEV = 7'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_w;
    logic       sda_oe;
    logic       lcl_we = 1'b0;
    logic [3:0] lcl_addr = 4'd0;
    logic [7:0] lcl_wdata = 8'h00;
    logic [7:0] lcl_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [16];
    int         mptr;
    logic [7:0] txd [$];
    logic [3:0] wr_q [$];
    logic       oe_seen;

    assign sda_w = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_w),
        .sda_oe    (sda_oe),
        .lcl_we    (lcl_we),
        .lcl_addr  (lcl_addr),
        .lcl_wdata (lcl_wdata),
        .lcl_rdata (lcl_rdata),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (wr_stb) wr_q.push_back(wr_addr);
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl) begin
            sda_m = 1'b1; wq(Q);
            sda_m = 1'b0; wq(Q);
            scl = 1'b0; wq(Q);
        end else begin
            sda_m = 1'b1; wq(Q);
            scl = 1'b1; wq(Q);
            sda_m = 1'b0; wq(Q);
            scl = 1'b0; wq(Q);
        end
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b; wq(Q);
        scl = 1'b1; wq(Q);
        r = sda_w; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    task automatic lcl_read(input int a, output logic [7:0] v);
        lcl_addr = 4'(a);
        wq(1);
        v = lcl_rdata;
    endtask

    task automatic lcl_write(input int a, input logic [7:0] d);
        lcl_addr = 4'(a);
        lcl_wdata = d;
        lcl_we = 1'b1;
        wq(1);
        lcl_we = 1'b0;
        mdl[a] = d;
        chk("lcl_no_wr_stb", 32'(wr_stb), 32'd0);
        chk("lcl_wr_rdata", 32'(lcl_rdata), 32'(d));
    endtask

    task automatic cmp_all(input string nm);
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            lcl_read(i, v);
            chk(nm, 32'(v), 32'(mdl[i]));
        end
    endtask

    task automatic tx_write(input logic [7:0] pbyte, input bit stop_en);
        logic a;
        int   exp_wr [$];
        wr_q.delete();
        i2c_start();
        write_byte({DEV, 1'b0}, a);
        chk("addr_ack", 32'(a), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd1);
        write_byte(pbyte, a);
        chk("ptr_ack", 32'(a), 32'd0);
        mptr = pbyte % 16;
        foreach (txd[i]) begin
            write_byte(txd[i], a);
            chk("data_ack", 32'(a), 32'd0);
            mdl[mptr] = txd[i];
            exp_wr.push_back(mptr);
            mptr = (mptr + 1) % 16;
        end
        if (stop_en) begin
            i2c_stop();
            chk("busy_after_stop", 32'(busy), 32'd0);
            chk("oe_after_stop", 32'(sda_oe), 32'd0);
        end
        chk("wr_stb_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        foreach (exp_wr[i]) begin
            if (i < wr_q.size()) chk("wr_addr", 32'(wr_q[i]), 32'(exp_wr[i]));
        end
    endtask

    task automatic tx_read(input int n);
        logic       a;
        logic [7:0] b;
        i2c_start();
        write_byte({DEV, 1'b1}, a);
        chk("rd_addr_ack", 32'(a), 32'd0);
        for (int i = 0; i < n; i++) begin
            read_byte(b, (i == n - 1));
            chk("rd_data", 32'(b), 32'(mdl[mptr]));
            mptr = (mptr + 1) % 16;
        end
        chk("rd_release_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        chk("rd_busy_after_stop", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    initial begin : main
        vec_t       vt [8];
        logic       a, r, hit;
        logic [7:0] v;
        logic [7:0] d33;
        int         kind, n;
        logic [6:0] badr;

        vt[0] = '{1'b0, 4'd0,  8'h00, 8'h00};
        vt[1] = '{1'b0, 4'd15, 8'hFF, 8'h00};
        vt[2] = '{1'b1, 4'd3,  8'hC3, 8'hC3};
        vt[3] = '{1'b0, 4'd7,  8'h00, 8'h00};
        vt[4] = '{1'b1, 4'd7,  8'h01, 8'h01};
        vt[5] = '{1'b0, 4'd3,  8'h99, 8'hC3};
        vt[6] = '{1'b1, 4'd3,  8'h3C, 8'h3C};
        vt[7] = '{1'b0, 4'd9,  8'h55, 8'h00};

        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mptr = 0;

        wq(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_stb", 32'(wr_stb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wq(2);

        for (int i = 0; i < 8; i++) begin
            lcl_addr  = vt[i].addr;
            lcl_wdata = vt[i].wdata;
            lcl_we    = vt[i].we;
            wq(1);
            lcl_we = 1'b0;
            if (vt[i].we) mdl[vt[i].addr] = vt[i].wdata;
            chk("vec_rdata", 32'(lcl_rdata), 32'(vt[i].exp));
            chk("vec_no_wr_stb", 32'(wr_stb), 32'd0);
        end

        // basic two-byte write
        txd = '{8'hA5, 8'h5A};
        tx_write(8'h02, 1'b1);
        lcl_read(3, v);
        chk("t1_reg3", 32'(v), 32'h5A);
        lcl_read(2, v);
        chk("t1_reg2", 32'(v), 32'hA5);

        // pointer write, repeated start, read two bytes
        txd.delete();
        tx_write(8'h02, 1'b0);
        tx_read(2);
        lcl_write(4, 8'hD4);
        tx_read(1);

        // wrong address
        oe_seen = 1'b0;
        i2c_start();
        write_byte({7'h3D, 1'b0}, a);
        chk("t3_nack", 32'(a), 32'd1);
        i2c_stop();
        chk("t3_oe_never", 32'(oe_seen), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        cmp_all("t3_regs");

        // pointer wrap
        txd = '{8'h11, 8'h22};
        tx_write(8'h0F, 1'b1);
        lcl_read(15, v);
        chk("t4_reg15", 32'(v), 32'h11);
        lcl_read(0, v);
        chk("t4_reg0", 32'(v), 32'h22);

        // local write racing bus write to the same register
        wr_q.delete();
        d33 = 8'h33;
        i2c_start();
        write_byte({DEV, 1'b0}, a);
        chk("t5_addr_ack", 32'(a), 32'd0);
        write_byte(8'h05, a);
        chk("t5_ptr_ack", 32'(a), 32'd0);
        for (int i = 7; i >= 1; i--) i2c_bit(d33[i], r);
        lcl_addr  = 4'd5;
        lcl_wdata = 8'h77;
        lcl_we    = 1'b1;
        hit = 1'b0;
        fork
            i2c_bit(d33[0], r);
            begin
                for (int k = 0; k < 200 && !hit; k++) begin
                    @(negedge clk);
                    if (wr_stb) hit = 1'b1;
                end
                lcl_we = 1'b0;
            end
        join
        chk("t5_race_wr_stb", 32'(hit), 32'd1);
        i2c_bit(1'b1, a);
        chk("t5_data_ack", 32'(a), 32'd0);
        mdl[5] = 8'h33;
        mptr = 6;
        lcl_read(5, v);
        chk("t5_bus_wins", 32'(v), 32'h33);
        // stop in the middle of the next byte
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
        i2c_stop();
        chk("t5_midstop_oe", 32'(sda_oe), 32'd0);
        chk("t5_midstop_busy", 32'(busy), 32'd0);
        chk("t5_single_wr", 32'(wr_q.size()), 32'd1);
        lcl_read(6, v);
        chk("t5_reg6_kept", 32'(v), 32'(mdl[6]));

        // reset while the target holds the ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(((8'h78 >> i) & 8'h01) != 0, r);
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            if (sda_oe) hit = 1'b1;
            else @(negedge clk);
        end
        chk("t6_ack_driven", 32'(hit), 32'd1);
        rst_n = 1'b0;
        wq(1);
        chk("t6_rst_oe", 32'(sda_oe), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mptr = 0;
        sda_m = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        lcl_read(2, v);
        chk("t6_regs_cleared", 32'(v), 32'h00);
        lcl_write(0, 8'h9E);
        tx_read(1);

`ifdef I2C_TGT_GLITCH_FILTER_EN
        // one-clock SCL low pulse inside a data bit
        wr_q.delete();
        d33 = 8'hC6;
        i2c_start();
        write_byte({DEV, 1'b0}, a);
        chk("gl_addr_ack", 32'(a), 32'd0);
        write_byte(8'h08, a);
        chk("gl_ptr_ack", 32'(a), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                sda_m = d33[i]; wq(Q);
                scl = 1'b1; wq(2);
                scl = 1'b0; wq(1);
                scl = 1'b1; wq(Q - 3);
                wq(Q);
                scl = 1'b0; wq(Q);
            end else begin
                i2c_bit(d33[i], r);
            end
        end
        i2c_bit(1'b1, a);
        chk("gl_data_ack", 32'(a), 32'd0);
        i2c_stop();
        mdl[8] = 8'hC6;
        mptr = 9;
        chk("gl_wr_count", 32'(wr_q.size()), 32'd1);
        lcl_read(8, v);
        chk("gl_reg8", 32'(v), 32'hC6);
`endif

        // random traffic against the model
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                n = $urandom_range(1, 4);
                txd.delete();
                for (int i = 0; i < n; i++) txd.push_back(8'($urandom));
                tx_write(8'($urandom), 1'b1);
            end else if (kind == 1) begin
                txd.delete();
                tx_write(8'($urandom), 1'b0);
                tx_read($urandom_range(1, 3));
            end else if (kind == 2) begin
                badr = 7'($urandom);
                if (badr == DEV) badr = DEV ^ 7'h01;
                oe_seen = 1'b0;
                i2c_start();
                write_byte({badr, 1'($urandom)}, a);
                chk("rnd_nack", 32'(a), 32'd1);
                i2c_stop();
                chk("rnd_oe_never", 32'(oe_seen), 32'd0);
            end else begin
                lcl_write($urandom_range(0, 15), 8'($urandom));
            end
        end
        cmp_all("final_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
